// File: rtl/dp_pkg.sv
// Shared definitions for the data-processing issue controller: ALU opcodes,
// flag bit positions, condition codes and the FSM state type.
package dp_pkg;

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_EOR = 5'b00001;
    localparam logic [4:0] ALU_SUB = 5'b00010;
    localparam logic [4:0] ALU_RSB = 5'b00011;
    localparam logic [4:0] ALU_ADD = 5'b00100;
    localparam logic [4:0] ALU_TST = 5'b01000;
    localparam logic [4:0] ALU_TEQ = 5'b01001;
    localparam logic [4:0] ALU_CMP = 5'b01010;
    localparam logic [4:0] ALU_CMN = 5'b01011;
    localparam logic [4:0] ALU_ORR = 5'b01100;
    localparam logic [4:0] ALU_MOV = 5'b01101;
    localparam logic [4:0] ALU_BIC = 5'b01110;
    localparam logic [4:0] ALU_MVN = 5'b01111;
    localparam logic [4:0] ALU_NOP = 5'b11111;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WB
    } state_t;

    // TST/TEQ/CMP/CMN: opcodes 10xx only update flags
    function automatic logic is_compare(input logic [3:0] opcode);
        return opcode[3:2] == 2'b10;
    endfunction

    // ADC/SBC/RSC are not handled by this ALU
    function automatic logic is_unsupported(input logic [3:0] opcode);
        return (opcode == 4'b0101) || (opcode == 4'b0110) || (opcode == 4'b0111);
    endfunction

endpackage

// File: rtl/dp_cond_check.sv
// ARM condition-code evaluator: pass is high when cond holds for the given
// Z/C/N/V flags. NV (1111) never passes.
module dp_cond_check
    import dp_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic z, c, n, v;

    always_comb begin
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        n = flags[FLAG_N];
        v = flags[FLAG_V];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/dp_issue_ctrl.sv
// Issue controller for ARM data-processing instructions: IDLE/EXEC/WB sequencing,
// operand selection, writeback and CPSR flag update. Macro DP_COND_EXEC_EN enables
// condition-code evaluation; otherwise every instruction executes as AL.
module dp_issue_ctrl
    import dp_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter logic [3:0] CPSR_INIT = 4'b0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rn_data,
    input  logic [DATA_W-1:0] rm_data,
    output logic [4:0]        alu_op,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic              wb_en,
    output logic [3:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        cpsr_flags,
    output logic              unsupported
);

    state_t            state, state_nxt;
    logic              imm_sel_q, set_flags_q;
    logic [3:0]        opcode_q, rd_q;
    logic [11:0]       op2_q;
    logic [DATA_W-1:0] rn_q, rm_q, res_q;
    logic [3:0]        flags_q;
    logic [4:0]        rot_sh;
    logic [31:0]       imm_rot;
    logic              cond_pass;
    logic              unused_bits;

`ifdef DP_COND_EXEC_EN
    logic [3:0] cond_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cond_q <= '0;
        else if (state == ST_IDLE && instr_valid)
            cond_q <= instr[31:28];
    end

    dp_cond_check u_cond_check (
        .cond  (cond_q),
        .flags (cpsr_flags),
        .pass  (cond_pass)
    );

    assign unused_bits = ^{instr[27:26], instr[19:16]};
`else
    assign cond_pass   = 1'b1;
    assign unused_bits = ^{instr[31:26], instr[19:16]};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imm_sel_q   <= 1'b0;
            set_flags_q <= 1'b0;
            opcode_q    <= '0;
            rd_q        <= '0;
            op2_q       <= '0;
            rn_q        <= '0;
            rm_q        <= '0;
            res_q       <= '0;
            flags_q     <= '0;
            cpsr_flags  <= CPSR_INIT;
        end else begin
            if (state == ST_IDLE && instr_valid) begin
                imm_sel_q   <= instr[25];
                opcode_q    <= instr[24:21];
                set_flags_q <= instr[20];
                rd_q        <= instr[15:12];
                op2_q       <= instr[11:0];
                rn_q        <= rn_data;
                rm_q        <= rm_data;
            end
            if (state == ST_EXEC) begin
                res_q   <= alu_result;
                flags_q <= alu_flags;
            end
            if (state == ST_WB && (set_flags_q || is_compare(opcode_q)))
                cpsr_flags <= flags_q;
        end
    end

    // 32-bit rotate-right of imm8; a shift by 32 yields zero, so rot=0 is safe
    always_comb begin
        rot_sh  = {op2_q[11:8], 1'b0};
        imm_rot = ({24'b0, op2_q[7:0]} >> rot_sh)
                | ({24'b0, op2_q[7:0]} << (6'd32 - {1'b0, rot_sh}));
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        alu_op      = ALU_NOP;
        alu_data1   = '0;
        alu_data2   = '0;
        wb_en       = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        unsupported = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                alu_op      = {1'b0, opcode_q};
                alu_data1   = rn_q;
                alu_data2   = imm_sel_q ? DATA_W'(imm_rot) : rm_q;
                unsupported = is_unsupported(opcode_q);
                state_nxt   = (unsupported || !cond_pass) ? ST_IDLE : ST_WB;
            end
            ST_WB: begin
                alu_op    = {1'b0, opcode_q};
                alu_data1 = rn_q;
                alu_data2 = imm_sel_q ? DATA_W'(imm_rot) : rm_q;
                wb_en     = !is_compare(opcode_q);
                wb_addr   = rd_q;
                wb_data   = res_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: doc/dp_issue_ctrl.md
DP_ISSUE_CTRL -- requirements
Module: dp_issue_ctrl

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width.
REQ-002 Parameter: CPSR_INIT, 4'b0000, flag register value after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 instr_valid  input  1  instruction offered.
REQ-006 instr_ready  output  1  block can accept an instruction.
REQ-007 instr  input  32  ARM data-processing word: [31:28] cond, [25] I, [24:21] opcode, [20] S, [19:16] Rn, [15:12] Rd, [11:0] operand2.
REQ-008 rn_data  input  DATA_W  Rn register value, sampled with instr.
REQ-009 rm_data  input  DATA_W  Rm register value (used when I=0), sampled with instr.
REQ-010 alu_op  output  5  operation code to ALU.
REQ-011 alu_data1 / alu_data2  output  DATA_W each  ALU operands.
REQ-012 alu_result  input  DATA_W  ALU result.
REQ-013 alu_flags  input  4  ALU flags, bit0 Z, bit1 C, bit2 N, bit3 V.
REQ-014 wb_en  output  1  one-cycle register write strobe.
REQ-015 wb_addr  output  4  destination register (Rd).
REQ-016 wb_data  output  DATA_W  write data.
REQ-017 cpsr_flags  output  4  current flags, same bit order as alu_flags.
REQ-018 unsupported  output  1  one-cycle pulse when ADC/SBC/RSC is received.

Function
REQ-019 FSM states IDLE, EXEC, WB; instr_ready SHALL be 1 only in IDLE.
REQ-020 Handshake: instr_valid && instr_ready at a rising edge SHALL latch instr, rn_data, rm_data and move IDLE->EXEC.
REQ-021 alu_op SHALL be {1'b0, opcode}: AND 00000, EOR 00001, SUB 00010, RSB 00011, ADD 00100, TST 01000, TEQ 01001, CMP 01010, CMN 01011, ORR 01100, MOV 01101, BIC 01110, MVN 01111.
REQ-022 alu_data1 SHALL be latched Rn; alu_data2 SHALL be rm_data when I=0, else imm8 = operand2[7:0] rotated right by 2*operand2[11:8], zero-extended to DATA_W.
REQ-023 alu_op/data outputs SHALL be held stable from EXEC through WB; in IDLE alu_op SHALL be 5'b11111 (ALU default, zero result).
REQ-024 In EXEC, condition false SHALL go EXEC->IDLE with no writeback and no flag update; condition true SHALL go EXEC->WB, registering alu_result and alu_flags.
REQ-025 In WB, wb_en SHALL pulse for exactly one cycle with wb_addr=Rd and wb_data=registered result, except TST/TEQ/CMP/CMN, which SHALL never write; WB->IDLE unconditionally.
REQ-026 cpsr_flags SHALL load registered ALU flags in WB when S=1 or opcode is TST/TEQ/CMP/CMN; otherwise hold.
REQ-027 Latency: handshake at edge 0 -> wb_en high during cycle after edge 1 -> instr_ready high again after edge 2; throughput one instruction per 3 cycles.
REQ-028 Opcodes 0101/0110/0111 SHALL pulse unsupported in EXEC, return to IDLE, no writeback, no flag update.
REQ-029 Condition evaluation SHALL use cpsr_flags as of EXEC (flags written in WB of the previous instruction are visible); cond 1111 treated as never.

Reset
REQ-030 Reset low SHALL immediately force IDLE, cpsr_flags=CPSR_INIT, wb_en=0, unsupported=0, wb_addr=0, wb_data=0, alu_op=5'b11111, data outputs 0; an instruction in flight is discarded with no writeback.
REQ-031 First handshake SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-032 Macro DP_COND_EXEC_EN: defined -> full 15-condition evaluation (EQ..LE, AL) per REQ-024; undefined -> every instruction treated as AL, cond field ignored, EXEC->WB always.

Structure
REQ-033 Shared package dp_pkg SHALL hold the 5-bit ALU opcode constants, flag bit indices (Z=0,C=1,N=2,V=3), cond-code constants and the FSM state typedef.
REQ-034 Sub-module dp_cond_check (cond[3:0], flags[3:0] -> pass) SHALL be instantiated only when DP_COND_EXEC_EN is defined.

Verification
REQ-035 ADD R2,R0,R1 (cond AL, S=1), rn=3, rm=7 -> alu_op 00100, wb_en one cycle, wb_addr 2, wb_data 10, cpsr_flags 0000.
REQ-036 CMP R0,#5 (I=1, imm8=5, rot=0), rn=5, ALU returns Z=1 -> no wb_en, cpsr_flags 0001; following MOVEQ R3,#1 writes R3=1; MOVNE R4,#1 does not write.
REQ-037 MOV R1,#0xFF rot=4 -> alu_data2 0xFF000000, wb_data 0xFF000000, cpsr unchanged (S=0).
REQ-038 ADC opcode offered -> unsupported one-cycle pulse, no wb_en, instr_ready back after 2 cycles.
REQ-039 Reset asserted during EXEC of ADD -> no wb_en, cpsr_flags=CPSR_INIT, instr_ready 1 after release.
REQ-040 DP_COND_EXEC_EN undefined, MOVEQ R3,#1 with Z=0 -> R3 written with 1.
